// File: rtl/hex_scan_driver.sv
// Scans a latched 16-bit hex value onto a common-anode 4-digit 7-segment display.
// Optional macro HEX_SCAN_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module hex_scan_driver #(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value_in,
  input  logic        display_en,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n,
  output logic        frame_start
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow;

  logic          tick;
  logic          guard;
  logic          lz;
  logic [3:0]    nib;
  logic [6:0]    seg_d;

  always_comb begin
    tick = (cnt == LAST);
    // int compare keeps GUARD = 0 a clean never-true test
    guard = (int'(cnt) < GUARD);
    nib = shadow[{idx, 2'b00} +: 4];
  end

  always_comb begin
    seg_d = 7'h7F;
    unique case (nib)
      4'h0: seg_d = 7'b1000000;
      4'h1: seg_d = 7'b1111001;
      4'h2: seg_d = 7'b0100100;
      4'h3: seg_d = 7'b0110000;
      4'h4: seg_d = 7'b0011001;
      4'h5: seg_d = 7'b0010010;
      4'h6: seg_d = 7'b0000010;
      4'h7: seg_d = 7'b1111000;
      4'h8: seg_d = 7'b0000000;
      4'h9: seg_d = 7'b0010000;
      4'hA: seg_d = 7'b0001000;
      4'hB: seg_d = 7'b0000011;
      4'hC: seg_d = 7'b1000110;
      4'hD: seg_d = 7'b0100001;
      4'hE: seg_d = 7'b0000110;
      4'hF: seg_d = 7'b0001110;
    endcase
  end

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
  always_comb begin
    lz = 1'b0;
    unique case (idx)
      2'd3: lz = (shadow[15:12] == 4'h0);
      2'd2: lz = (shadow[15:8] == 8'h00);
      2'd1: lz = (shadow[15:4] == 12'h000);
      2'd0: lz = 1'b0;
    endcase
  end
`else
  always_comb lz = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt         <= '0;
      idx         <= 2'd0;
      shadow      <= 16'h0000;
      an_n        <= 4'hF;
      seg_n       <= 7'h7F;
      frame_start <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + ONE;
      if (tick) idx <= idx + 2'd1;
      if (tick && idx == 2'd3) shadow <= value_in;
      frame_start <= tick && (idx == 2'd3);
      if (!display_en || guard) begin
        an_n  <= 4'hF;
        seg_n <= 7'h7F;
      end else begin
        an_n  <= ~(4'b0001 << idx);
        seg_n <= lz ? 7'h7F : seg_d;
      end
    end
  end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Bench for hex_scan_driver: cycle scoreboard plus directed slot checks.
// A second instance with GUARD = 0 checks that anodes never all go dark.
module tb_hex_scan_driver;
  localparam int SD = 4;
  localparam int G  = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        display_en = 1'b1;
  logic [15:0] value_in = 16'h0000;
  logic [6:0]  seg_n, seg0;
  logic [3:0]  an_n, an0;
  logic        frame_start, fs0;

  always #5 clk = ~clk;

  hex_scan_driver #(.SCAN_DIV(SD), .GUARD(G)) dut (
    .clk(clk), .reset_n(reset_n), .value_in(value_in),
    .display_en(display_en), .seg_n(seg_n), .an_n(an_n),
    .frame_start(frame_start)
  );

  hex_scan_driver #(.SCAN_DIV(SD), .GUARD(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .value_in(value_in),
    .display_en(display_en), .seg_n(seg0), .an_n(an0),
    .frame_start(fs0)
  );

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int total = 0;
  int bad = 0;
  string phase = "reset";

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: advances at each edge, pushes the output it expects
  int          m_cnt = 0;
  int          m_idx = 0;
  logic [15:0] m_sh = 16'h0;
  logic [11:0] sb_q [$];
  logic [11:0] m_e;
  logic [3:0]  m_a;
  logic [6:0]  m_s;
  logic        m_fs;
  logic        ok0 = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_e = {4'hF, 7'h7F, 1'b0};
      m_cnt = 0;
      m_idx = 0;
      m_sh = 16'h0;
    end else begin
      m_fs = (m_cnt == SD - 1) && (m_idx == 3);
      if (!display_en || m_cnt < G) begin
        m_a = 4'hF;
        m_s = 7'h7F;
      end else begin
        m_a = 4'hF;
        m_a[m_idx] = 1'b0;
        m_s = seg_tab[m_sh[m_idx*4 +: 4]];
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
        if (m_idx > 0 && (m_sh >> (4 * m_idx)) == 16'h0) m_s = 7'h7F;
`endif
      end
      m_e = {m_a, m_s, m_fs};
      if (m_cnt == SD - 1) begin
        m_cnt = 0;
        if (m_idx == 3) begin
          m_idx = 0;
          m_sh = value_in;
        end else begin
          m_idx++;
        end
      end else begin
        m_cnt++;
      end
    end
    sb_q.push_back(m_e);
    ok0 = reset_n && display_en;
  end

  int          cyc = 0;
  int          last_fs = -1;
  logic [11:0] exp_v;

  always @(negedge clk) begin
    cyc++;
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      check_eq(phase, {20'h0, an_n, seg_n, frame_start}, {20'h0, exp_v});
    end
    if (ok0) check_eq("guard0_an_dark", {31'h0, an0 == 4'hF}, 32'h0);
    if (!reset_n) begin
      last_fs = -1;
    end else if (frame_start) begin
      if (last_fs >= 0) check_eq("fs_period", cyc - last_fs, 16);
      last_fs = cyc;
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs();
    int k;
    k = 0;
    @(negedge clk);
    while (!frame_start && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("fs_wait", {31'h0, frame_start}, 32'h1);
  endtask

  task automatic slot(string tag, logic [3:0] a, logic [6:0] s);
    check_eq({tag, "_an"}, {28'h0, an_n}, {28'h0, a});
    check_eq({tag, "_seg"}, {25'h0, seg_n}, {25'h0, s});
  endtask

  initial begin
    step(3);
    check_eq("rst_an", {28'h0, an_n}, 32'hF);
    check_eq("rst_seg", {25'h0, seg_n}, 32'h7F);
    check_eq("rst_fs", {31'h0, frame_start}, 32'h0);
    reset_n = 1'b1;
    phase = "first_frame";
    step(2);
    slot("first_d0", 4'b1110, 7'b1000000);
    wait_fs();

    phase = "v1234";
    value_in = 16'h1234;
    wait_fs();
    step(1);
    slot("guard", 4'hF, 7'h7F);
    step(1);
    slot("d0_4", 4'b1110, 7'b0011001);
    step(4);
    slot("d1_3", 4'b1101, 7'b0110000);
    value_in = 16'hABCD;
    phase = "late_change";
    step(4);
    slot("d2_2", 4'b1011, 7'b0100100);
    step(4);
    slot("d3_1", 4'b0111, 7'b1111001);
    wait_fs();
    step(2);
    slot("abcd_d0", 4'b1110, 7'b0100001);

    phase = "disable";
    step(3);
    display_en = 1'b0;
    step(10);
    slot("dis", 4'hF, 7'h7F);
    display_en = 1'b1;
    phase = "reenable";
    wait_fs();
    wait_fs();

    phase = "walk";
    for (int n = 0; n < 16; n++) begin
      value_in = 16'(n);
      wait_fs();
      step(2);
      slot("walk_d0", 4'b1110, seg_tab[n]);
    end

    phase = "mid_reset";
    wait_fs();
    step(10);
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(2);
    slot("post_rst_d0", 4'b1110, 7'b1000000);

    phase = "v0040";
    value_in = 16'h0040;
    wait_fs();
    step(10);
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    slot("lz_d2", 4'b1011, 7'h7F);
    step(4);
    slot("lz_d3", 4'b0111, 7'h7F);
`else
    slot("lz_d2", 4'b1011, 7'b1000000);
    step(4);
    slot("lz_d3", 4'b0111, 7'b1000000);
`endif

    phase = "random";
    for (int r = 0; r < 6; r++) begin
      value_in = 16'($urandom);
      display_en = ($urandom_range(0, 3) != 0);
      step(13);
    end
    display_en = 1'b1;
    step(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
